// File: rtl/if_id_ins_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of {pc, instruction}.
// Optional branch predecode bit per entry, enabled by defining IF_ID_BRANCH_HINT_EN.
module if_id_ins_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            fetch_valid,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic [31:0]     fetch_ins,
  output logic            fetch_ready,
  output logic            dec_valid,
  output logic [PC_W-1:0] dec_pc,
  output logic [31:0]     dec_ins,
  input  logic            dec_ready,
  output logic            dec_is_branch,
  output logic [3:0]      occupancy
);

  localparam int          PTR_W = $clog2(DEPTH);
  localparam logic [3:0]  FULL  = 4'(DEPTH);
  localparam logic [31:0] NOP   = 32'h00000013;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       count;
  logic             push;
  logic             pop;

  logic [PC_W-1:0]  pc_mem  [DEPTH];
  logic [31:0]      ins_mem [DEPTH];

  assign fetch_ready = (count != FULL);
  assign dec_valid   = (count != '0);
  assign occupancy   = count;
  assign push        = fetch_valid & fetch_ready;
  assign pop         = dec_valid & dec_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; a write during flush/reset lands in a slot that is
  // immediately treated as empty, so it is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= fetch_ins;
    end
  end

  assign dec_pc  = dec_valid ? pc_mem[rd_ptr]  : '0;
  assign dec_ins = dec_valid ? ins_mem[rd_ptr] : NOP;

`ifdef IF_ID_BRANCH_HINT_EN
  logic br_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push) br_mem[wr_ptr] <= (fetch_ins[6:0] == 7'b1100011);
  end

  assign dec_is_branch = dec_valid & br_mem[rd_ptr];
`else
  assign dec_is_branch = 1'b0;
`endif

endmodule
